// File: rtl/rfphoenix_mem_resp_queue_pkg.sv
// Shared types for the rfPhoenix memory-response path: the response record and
// the thread/register widths used to index the pending-target bitmaps.
package rfPhoenixPkg;

  localparam int NTHREADS = 4;
  localparam int THR_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int TGT_W    = 7;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TGT_W-1:0]  tgt;
    logic [THR_W-1:0]  thread;
  } MemoryArg_t;

endpackage

// File: rtl/rfphoenix_mem_resp_bitmap.sv
// Per-thread pending-target bitmaps: set on enqueue, clear on consume,
// with a thread rollback wiping that thread's whole row.
module rfphoenix_mem_resp_bitmap
  import rfPhoenixPkg::*;
#(
  parameter int NTHREADS = rfPhoenixPkg::NTHREADS,
  parameter int NREGS    = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               set_en,
  input  logic [THR_W-1:0]                   set_thr,
  input  logic [TGT_W-1:0]                   set_tgt,
  input  logic                               clr_en,
  input  logic [THR_W-1:0]                   clr_thr,
  input  logic [TGT_W-1:0]                   clr_tgt,
  input  logic [NTHREADS-1:0]                rollback,
  output logic [NTHREADS-1:0][NREGS-1:0]     bitmaps
);

  logic [NTHREADS-1:0][NREGS-1:0] bm_q, bm_d;

  // Clear first so a same-bit set wins; rollback last so it overrides both.
  always_comb begin
    bm_d = bm_q;
    if (clr_en) bm_d[clr_thr][clr_tgt] = 1'b0;
    if (set_en) bm_d[set_thr][set_tgt] = 1'b1;
    for (int t = 0; t < NTHREADS; t++)
      if (rollback[t]) bm_d[t] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) bm_q <= '0;
    else     bm_q <= bm_d;
  end

  assign bitmaps = bm_q;

endmodule

// File: rtl/rfphoenix_mem_resp_queue.sv
// In-order memory-response queue with per-thread squash; squashed entries are
// dropped at the head one per cycle without consumer involvement.
module rfphoenix_mem_resp_queue
  import rfPhoenixPkg::*;
#(
  parameter int DEP       = 16,
  parameter int NTHREADS  = rfPhoenixPkg::NTHREADS,
  parameter int NREGS     = 128,
  parameter int AF_MARGIN = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr,
  input  MemoryArg_t                     di,
  input  logic                           rd,
  output MemoryArg_t                     dout,
  output logic                           v,
  output logic [$clog2(DEP):0]           cnt,
  output logic                           full,
  output logic                           almost_full,
  output logic                           empty,
  output logic                           overflow,
  input  logic [NTHREADS-1:0]            rollback,
  output logic [NTHREADS-1:0]            thread_busy,
  output logic [NTHREADS-1:0][NREGS-1:0] rollback_bitmaps
);

  localparam int PW = $clog2(DEP);
  localparam int CW = PW + 1;

  MemoryArg_t       mem [DEP];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [DEP-1:0]   live_q, live_d;
  logic [THR_W-1:0] thr_q [DEP];
  logic [THR_W-1:0] thr_d [DEP];

  logic is_live, is_dead, rd_acc, pop, wr_acc;

  assign full        = (cnt_q == CW'(DEP));
  assign empty       = (cnt_q == '0);
  assign almost_full = (cnt_q >= CW'(DEP - AF_MARGIN));
  assign cnt         = cnt_q;
  assign overflow    = ovf_q;

  always_comb begin
    is_live = live_q[head_q] & ~empty;
    is_dead = ~live_q[head_q] & ~empty;
    rd_acc  = rd & is_live;
    pop     = rd_acc | is_dead;
    wr_acc  = wr & ~full & ~rollback[di.thread];
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(wr_acc);
    cnt_d   = cnt_q + CW'(wr_acc) - CW'(pop);
    ovf_d   = wr & full;
    // Live bits are cleared on pop so that live alone implies the slot is occupied.
    for (int i = 0; i < DEP; i++) begin
      live_d[i] = live_q[i] & ~rollback[thr_q[i]];
      thr_d[i]  = thr_q[i];
    end
    if (pop) live_d[head_q] = 1'b0;
    if (wr_acc) begin
      live_d[tail_q] = 1'b1;
      thr_d[tail_q]  = di.thread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      live_q <= '0;
      for (int i = 0; i < DEP; i++) thr_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      live_q <= live_d;
      for (int i = 0; i < DEP; i++) thr_q[i] <= thr_d[i];
    end
  end

  // Payload storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[tail_q] <= di;
  end

  assign v    = is_live;
  assign dout = is_live ? mem[head_q] : '0;

  always_comb begin
    thread_busy = '0;
    for (int t = 0; t < NTHREADS; t++)
      for (int i = 0; i < DEP; i++)
        if (live_q[i] && (thr_q[i] == THR_W'(t))) thread_busy[t] = 1'b1;
  end

  rfphoenix_mem_resp_bitmap #(
    .NTHREADS (NTHREADS),
    .NREGS    (NREGS)
  ) u_bitmap (
    .clk      (clk),
    .rst      (rst),
    .set_en   (wr_acc),
    .set_thr  (di.thread),
    .set_tgt  (di.tgt),
    .clr_en   (rd_acc),
    .clr_thr  (dout.thread),
    .clr_tgt  (dout.tgt),
    .rollback (rollback),
    .bitmaps  (rollback_bitmaps)
  );

endmodule
